// File: rtl/rat_path_checker.sv
// rtl/rat_path_checker.sv - replays a maze move stream and flags whether it reaches the goal legally
module rat_path_checker #(
  parameter int N  = 16,
  parameter int AW = 2 * $clog2(N),
  parameter int SW = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 move_valid,
  input  logic [1:0]           move,
  input  logic                 move_last,
  output logic                 move_ready,
  output logic [AW-1:0]        maze_addr,
  input  logic                 maze_rdata,
  output logic [$clog2(N)-1:0] row,
  output logic [$clog2(N)-1:0] col,
  output logic [SW-1:0]        steps,
  output logic                 busy,
  output logic                 ok,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam int LW = $clog2(N);
  localparam logic [LW-1:0] EDGE = LW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_next;

  logic [LW-1:0] cand_row, cand_col;
  logic [LW-1:0] nxt_row, nxt_col;
  logic          last_q;
  logic          oob_pend;
  logic          oob;
  logic          accept;
  logic          at_goal;

  // Candidate position and bounds test for the move currently offered.
  always_comb begin
    nxt_row = row;
    nxt_col = col;
    oob     = 1'b0;
    case (move)
      2'b00: begin oob = (row == '0);   nxt_row = row - LW'(1); end
      2'b01: begin oob = (col == EDGE); nxt_col = col + LW'(1); end
      2'b10: begin oob = (col == '0);   nxt_col = col - LW'(1); end
      default: begin oob = (row == EDGE); nxt_row = row + LW'(1); end
    endcase
  end

  assign move_ready = (state == S_WAIT);
  assign accept     = move_valid && move_ready && !start;
  assign busy       = (state == S_WAIT) || (state == S_CHECK);
  assign at_goal    = (cand_row == EDGE) && (cand_col == EDGE);
  assign maze_addr  = (state == S_CHECK) ? AW'({cand_row, cand_col}) : AW'({row, col});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = S_WAIT;
    end else begin
      case (state)
        S_WAIT: begin
          if (accept) state_next = oob ? S_ERR : S_CHECK;
        end
        S_CHECK: begin
          if (maze_rdata)  state_next = S_ERR;
          else if (last_q) state_next = at_goal ? S_DONE : S_ERR;
          else             state_next = S_WAIT;
        end
        default: state_next = state;
      endcase
    end
  end

  // An out-of-bounds move skips CHECK but its error lands one edge later,
  // so ok/err always appear one edge after the accepting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row      <= '0;
      col      <= '0;
      cand_row <= '0;
      cand_col <= '0;
      last_q   <= 1'b0;
      oob_pend <= 1'b0;
      steps    <= '0;
      ok       <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else if (start) begin
      row      <= '0;
      col      <= '0;
      cand_row <= '0;
      cand_col <= '0;
      last_q   <= 1'b0;
      oob_pend <= 1'b0;
      steps    <= '0;
      ok       <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      oob_pend <= 1'b0;
      if (oob_pend) begin
        err      <= 1'b1;
        err_code <= 2'b01;
      end
      if (accept) begin
        if (oob) begin
          oob_pend <= 1'b1;
        end else begin
          cand_row <= nxt_row;
          cand_col <= nxt_col;
          last_q   <= move_last;
        end
      end
      if (state == S_CHECK) begin
        if (maze_rdata) begin
          err      <= 1'b1;
          err_code <= 2'b10;
        end else begin
          row <= cand_row;
          col <= cand_col;
          if (steps != {SW{1'b1}}) steps <= steps + SW'(1);
          if (last_q) begin
            if (at_goal) begin
              ok <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= 2'b11;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rat_path_checker.sv
// tb/tb_rat_path_checker.sv - scoreboard bench for rat_path_checker on a 4x4 maze
module tb_rat_path_checker;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int SW = 10;

  logic          clk;
  logic          rst;
  logic          start;
  logic          move_valid;
  logic [1:0]    move;
  logic          move_last;
  logic          move_ready;
  logic [AW-1:0] maze_addr;
  logic          maze_rdata;
  logic [1:0]    row;
  logic [1:0]    col;
  logic [SW-1:0] steps;
  logic          busy;
  logic          ok;
  logic          err;
  logic [1:0]    err_code;

  logic maze [0:15];
  assign maze_rdata = maze[maze_addr];

  rat_path_checker #(.N(N), .AW(AW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .move_valid(move_valid), .move(move),
    .move_last(move_last), .move_ready(move_ready), .maze_addr(maze_addr),
    .maze_rdata(maze_rdata), .row(row), .col(col), .steps(steps), .busy(busy),
    .ok(ok), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ok;
    logic       err;
    logic [1:0] code;
    logic [1:0] row;
    logic [1:0] col;
    logic [9:0] steps;
  } res_t;

  res_t exp_q[$];
  res_t exp_r;
  int   compared   = 0;
  int   mismatched = 0;
  logic prev_term  = 1'b0;
  time  acc_time   = 0;
  time  prev_acc   = 0;

  task automatic check(input string name, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic o, input logic e, input logic [1:0] c,
                          input logic [1:0] r, input logic [1:0] cl, input logic [9:0] s);
    res_t t;
    t = '{o, e, c, r, cl, s};
    exp_q.push_back(t);
  endtask

  // Monitor: every new terminal result is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      prev_term = 1'b0;
    end else begin
      if ((ok || err) && !prev_term) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_result: got ok=%0d err=%0d expected no result", ok, err);
        end else begin
          exp_r = exp_q.pop_front();
          check("res_ok", ok, exp_r.ok);
          check("res_err", err, exp_r.err);
          check("res_err_code", err_code, exp_r.code);
          check("res_row", row, exp_r.row);
          check("res_col", col, exp_r.col);
          check("res_steps", steps, exp_r.steps);
        end
      end
      prev_term = ok || err;
    end
  end

  task automatic do_start;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input logic [1:0] m, input logic l);
    int n = 0;
    @(negedge clk);
    while (!move_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!move_ready) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout: got move_ready=0 expected 1 within 20 cycles");
    end else begin
      move_valid = 1'b1;
      move       = m;
      move_last  = l;
      @(posedge clk);
      prev_acc = acc_time;
      acc_time = $time;
      #1 move_valid = 1'b0;
    end
  endtask

  task automatic wait_term;
    int n = 0;
    while (!(ok || err) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(ok || err)) begin
      compared++;
      mismatched++;
      $display("FAIL result_timeout: got ok=0 err=0 expected a result within 20 cycles");
    end
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, move_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ok"}, ok, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_code"}, err_code, 0);
    check({tag, "_row"}, row, 0);
    check({tag, "_col"}, col, 0);
    check({tag, "_steps"}, steps, 0);
    check({tag, "_addr"}, maze_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] path6 [0:5];
    logic [1:0] path8 [0:7];
    path6 = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11};
    path8 = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11};
    for (int i = 0; i < 16; i++) maze[i] = 1'b0;
    rst = 1'b0; start = 1'b0; move_valid = 1'b0; move = 2'b00; move_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b1;

    // Full legal path on an open maze, one move every two cycles.
    do_start;
    check("start_ready", move_ready, 1);
    check("start_busy", busy, 1);
    push_exp(1'b1, 1'b0, 2'b00, 2'd3, 2'd3, 10'd6);
    for (int i = 0; i < 6; i++) begin
      send(path6[i], i == 5);
      if (i > 0) check("accept_gap", int'((acc_time - prev_acc) / 10), 2);
    end
    wait_term;
    check("done_ready", move_ready, 0);
    check("done_busy", busy, 0);

    // Out of bounds on the first move: err one edge after accept.
    do_start;
    push_exp(1'b0, 1'b1, 2'b01, 2'd0, 2'd0, 10'd0);
    send(2'b00, 1'b0);
    check("oob_err_at_A", err, 0);
    @(posedge clk);
    #1 check("oob_err_at_A1", err, 1);
    wait_term;

    // Wall at (0,1).
    maze[1] = 1'b1;
    do_start;
    push_exp(1'b0, 1'b1, 2'b10, 2'd0, 2'd0, 10'd0);
    send(2'b01, 1'b0);
    check("wall_check_addr", maze_addr, 1);
    wait_term;
    maze[1] = 1'b0;

    // Last move not on goal.
    do_start;
    push_exp(1'b0, 1'b1, 2'b11, 2'd1, 2'd1, 10'd2);
    send(2'b01, 1'b0);
    send(2'b11, 1'b1);
    wait_term;

    // Restart mid-path, then pass through the goal before the last move.
    do_start;
    send(2'b01, 1'b0);
    send(2'b01, 1'b0);
    do_start;
    check("restart_steps", steps, 0);
    check("restart_row", row, 0);
    check("restart_col", col, 0);
    check("restart_ok", ok, 0);
    check("restart_err", err, 0);
    check("restart_busy", busy, 1);
    push_exp(1'b1, 1'b0, 2'b00, 2'd3, 2'd3, 10'd8);
    for (int i = 0; i < 8; i++) send(path8[i], i == 7);
    wait_term;

    // Asynchronous reset during CHECK, then start racing a held move.
    do_start;
    send(2'b01, 1'b0);
    #2 rst = 1'b0;
    #1 check_reset_vals("async_rst");
    move_valid = 1'b1;
    move       = 2'b01;
    move_last  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("held_valid_ready", move_ready, 0);
    check("held_valid_steps", steps, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_wins_ready", move_ready, 1);
    check("start_wins_addr", maze_addr, 0);
    move_valid = 1'b0;
    repeat (2) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
